// File: rtl/spi_regbank_if.sv
// SPI-slave-facing register bus: address, write strobe/data, fast commands, read data and status byte.
interface spi_regbank_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [REG_W-1:0]  wr_data;
  logic              wr_vld;
  logic [REG_W-1:0]  rd_data;
  logic [7:0]        status;
  logic [5:0]        fastcmd;
  logic              fastcmd_vld;

  modport master (
    output reg_addr, wr_data, wr_vld, fastcmd, fastcmd_vld,
    input  rd_data, status
  );

  modport slave (
    input  reg_addr, wr_data, wr_vld, fastcmd, fastcmd_vld,
    output rd_data, status
  );
endinterface

// File: rtl/spi_regbank.sv
// Register bank behind the SPI slave: CFG registers, sticky W1C FLAGS with MASK/irq, fast-command soft reset/start.
// Optional feature: define SPI_REGBANK_EVT_SYNC_EN for a 2-flop synchroniser plus rising-edge detect on event_i.
module spi_regbank #(
  parameter int ADDR_W   = 3,
  parameter int REG_W    = 8,
  parameter int SRST_CYC = 4
) (
  input  logic                              clk,
  input  logic                              nrst,
  spi_regbank_if.slave                      bus,
  input  logic [7:0]                        event_i,
  output logic [(2**ADDR_W-2)*REG_W-1:0]    cfg_o,
  output logic                              irq_o,
  output logic                              start_o,
  output logic                              soft_rst_o
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NUM_CFG  = NUM_REGS - 2;
  localparam logic [ADDR_W-1:0] FLAGS_ADDR = ADDR_W'(NUM_REGS - 2);
  localparam logic [ADDR_W-1:0] MASK_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [5:0] CMD_SRST  = 6'h01;
  localparam logic [5:0] CMD_CLRF  = 6'h02;
  localparam logic [5:0] CMD_START = 6'h03;

  typedef enum logic {ST_IDLE, ST_SRST} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [REG_W-1:0] cfg_q [NUM_CFG];
  logic [7:0]       flags_q, mask_q, flags_clr, evt_set;
  logic [3:0]       wr_cnt_q;
  logic             badcmd_q;
  logic             in_srst, wr_en, cmd_en, srst_go;
  logic [REG_W-1:0] rd_mux;

  assign in_srst = (state_q == ST_SRST);
  assign wr_en   = bus.wr_vld && !in_srst;
  // A simultaneous write wins over a fast command.
  assign cmd_en  = bus.fastcmd_vld && !bus.wr_vld && !in_srst;
  assign srst_go = cmd_en && (bus.fastcmd == CMD_SRST);

`ifdef SPI_REGBANK_EVT_SYNC_EN
  logic [7:0] evt_s1, evt_s2, evt_d;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      evt_s1 <= '0;
      evt_s2 <= '0;
      evt_d  <= '0;
    end else begin
      evt_s1 <= event_i;
      evt_s2 <= evt_s1;
      evt_d  <= evt_s2;
    end
  end
  assign evt_set = evt_s2 & ~evt_d;
`else
  assign evt_set = event_i;
`endif

  // NOTE: state is written with <= only, so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      start_o    <= 1'b0;
      soft_rst_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (srst_go) begin
            state_q    <= ST_SRST;
            cnt_q      <= 4'(SRST_CYC);
            soft_rst_o <= 1'b1;
          end else if (cmd_en && bus.fastcmd == CMD_START) begin
            start_o <= 1'b1;
          end
        end
        ST_SRST: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= ST_IDLE;
            soft_rst_o <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    flags_clr = '0;
    if (wr_en && bus.reg_addr == FLAGS_ADDR) flags_clr = bus.wr_data[7:0];
    if (cmd_en && bus.fastcmd == CMD_CLRF)   flags_clr = 8'hFF;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the CFG array is reset because its contents drive cfg_o straight into the core.
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
      wr_cnt_q <= '0;
      badcmd_q <= 1'b0;
    end else if (in_srst || srst_go) begin
      // Clearing on entry as well keeps the bank at zero for the whole soft-reset pulse.
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + 4'd1;
        for (int i = 0; i < NUM_CFG; i++)
          if (bus.reg_addr == ADDR_W'(i)) cfg_q[i] <= bus.wr_data;
        if (bus.reg_addr == MASK_ADDR) mask_q <= bus.wr_data[7:0];
      end
      flags_q <= (flags_q & ~flags_clr) | evt_set;
      if (cmd_en) begin
        if (bus.fastcmd == CMD_CLRF)
          badcmd_q <= 1'b0;
        else if (bus.fastcmd != CMD_SRST && bus.fastcmd != CMD_START)
          badcmd_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.reg_addr == FLAGS_ADDR)
      rd_mux = REG_W'(flags_q);
    else if (bus.reg_addr == MASK_ADDR)
      rd_mux = REG_W'(mask_q);
    else
      for (int i = 0; i < NUM_CFG; i++)
        if (bus.reg_addr == ADDR_W'(i)) rd_mux = cfg_q[i];
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg_o[g*REG_W +: REG_W] = cfg_q[g];
  end

  assign irq_o       = |(flags_q & mask_q);
  assign bus.rd_data = rd_mux;
  assign bus.status  = {irq_o, in_srst, badcmd_q, 1'b0, wr_cnt_q};
endmodule

// File: tb/tb_spi_regbank.sv
// Scoreboard bench for spi_regbank: stimulus pushes expectations, a negedge monitor pops and compares them.
module tb_spi_regbank;
  localparam int ADDR_W = 3;
  localparam int REG_W  = 8;
  localparam int CFG_W  = (2**ADDR_W - 2) * REG_W;
`ifdef SPI_REGBANK_EVT_SYNC_EN
  localparam int EVT_LAT = 3;
`else
  localparam int EVT_LAT = 1;
`endif

  typedef enum logic [2:0] {K_RD, K_STATUS, K_IRQ, K_START, K_SRST, K_CFG} kind_t;
  typedef struct {
    kind_t       kind;
    logic [63:0] exp;
    string       name;
  } item_t;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [7:0]       event_i = '0;
  logic [CFG_W-1:0] cfg_o;
  logic             irq_o, start_o, soft_rst_o;

  spi_regbank_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  spi_regbank #(.ADDR_W(ADDR_W), .REG_W(REG_W), .SRST_CYC(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus.slave),
    .event_i    (event_i),
    .cfg_o      (cfg_o),
    .irq_o      (irq_o),
    .start_o    (start_o),
    .soft_rst_o (soft_rst_o)
  );

  always #5 clk = ~clk;

  item_t      sb[$];
  logic       probe = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_wcnt = '0;

  function automatic logic [63:0] actual(kind_t k);
    case (k)
      K_RD:     return 64'(bus.rd_data);
      K_STATUS: return 64'(bus.status);
      K_IRQ:    return 64'(irq_o);
      K_START:  return 64'(start_o);
      K_SRST:   return 64'(soft_rst_o);
      default:  return 64'(cfg_o);
    endcase
  endfunction

  always @(negedge clk) begin
    if (probe) begin
      while (sb.size() > 0) begin
        item_t it;
        logic [63:0] got;
        it  = sb.pop_front();
        got = actual(it.kind);
        checks++;
        if (got !== it.exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, got, it.exp);
        end
      end
    end
  end

  task automatic push(input kind_t k, input logic [63:0] v, input string n);
    item_t it;
    it.kind = k;
    it.exp  = v;
    it.name = n;
    sb.push_back(it);
  endtask

  task automatic sample();
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.reg_addr = a;
    bus.wr_data  = d;
    bus.wr_vld   = 1'b1;
    step();
    bus.wr_vld   = 1'b0;
    exp_wcnt     = exp_wcnt + 4'd1;
  endtask

  task automatic cmd(input logic [5:0] c);
    bus.fastcmd     = c;
    bus.fastcmd_vld = 1'b1;
    step();
    bus.fastcmd_vld = 1'b0;
  endtask

  task automatic pulse_event(input logic [7:0] e);
    event_i = e;
    step();
    event_i = '0;
    repeat (EVT_LAT - 1) step();
  endtask

  function automatic logic [63:0] st(input logic irq, input logic srst, input logic bad);
    return 64'({irq, srst, bad, 1'b0, exp_wcnt});
  endfunction

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [7:0] v, input string n);
    bus.reg_addr = a;
    push(K_RD, 64'(v), n);
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_addr = '0;
    bus.wr_data = '0;
    bus.wr_vld = 1'b0;
    bus.fastcmd = '0;
    bus.fastcmd_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(K_STATUS, 64'h00, "reset_status");
    push(K_IRQ, 64'h0, "reset_irq");
    push(K_CFG, 64'h0, "reset_cfg");
    push(K_START, 64'h0, "reset_start");
    push(K_SRST, 64'h0, "reset_srst");
    sample();
    nrst = 1'b1;
    step();

    // Basic writes and read-back.
    wr(3'd0, 8'hA5);
    wr(3'd5, 8'h3C);
    rd(3'd0, 8'hA5, "rd_cfg0");
    push(K_STATUS, st(1'b0, 1'b0, 1'b0), "status_wcnt2");
    push(K_CFG, 64'h3C00_0000_00A5, "cfg_o_after_writes");
    rd(3'd5, 8'h3C, "rd_cfg5");

    // Sixteen writes in total wrap WR_CNT; the last one sets MASK.
    for (int i = 1; i <= 13; i++) wr(3'd1, 8'(i));
    wr(3'd7, 8'hFF);
    push(K_STATUS, st(1'b0, 1'b0, 1'b0), "status_wcnt_wrap");
    rd(3'd7, 8'hFF, "rd_mask_ff");
    rd(3'd1, 8'h0D, "rd_cfg1_last");

    // Event flag, mask and irq.
    wr(3'd7, 8'h04);
    pulse_event(8'h04);
    push(K_IRQ, 64'h1, "irq_on_event");
    push(K_STATUS, st(1'b1, 1'b0, 1'b0), "status_irq");
    rd(3'd6, 8'h04, "flags_set");
    wr(3'd6, 8'h04);
    push(K_IRQ, 64'h0, "irq_after_w1c");
    rd(3'd6, 8'h00, "flags_w1c");
`ifdef SPI_REGBANK_EVT_SYNC_EN
    event_i = 8'h04;
    repeat (4) step();
    rd(3'd6, 8'h04, "flags_held_event");
    wr(3'd6, 8'h04);
    push(K_IRQ, 64'h0, "irq_held_w1c");
    rd(3'd6, 8'h00, "flags_held_w1c");
    event_i = '0;
`else
    event_i = 8'h04;
    wr(3'd6, 8'h04);
    event_i = '0;
    push(K_IRQ, 64'h1, "irq_set_wins");
    push(K_STATUS, st(1'b1, 1'b0, 1'b0), "status_set_wins");
    rd(3'd6, 8'h04, "flags_set_wins");
    wr(3'd6, 8'h04);
    rd(3'd6, 8'h00, "flags_clear_after");
`endif

    // Soft reset: four cycles high, write dropped, bank cleared.
    cmd(6'h01);
    exp_wcnt = '0;
    for (int k = 0; k < 4; k++) begin
      push(K_SRST, 64'h1, "srst_high");
      push(K_STATUS, 64'h40, "status_in_srst");
      sample();
      if (k == 1) begin
        bus.reg_addr = 3'd0;
        bus.wr_data  = 8'h77;
        bus.wr_vld   = 1'b1;
        step();
        bus.wr_vld   = 1'b0;
      end else begin
        step();
      end
    end
    push(K_SRST, 64'h0, "srst_done");
    push(K_STATUS, 64'h00, "status_after_srst");
    push(K_CFG, 64'h0, "cfg_after_srst");
    rd(3'd0, 8'h00, "cfg0_write_dropped");

    // START pulse, bad command, CLRF.
    cmd(6'h03);
    push(K_START, 64'h1, "start_pulse");
    sample();
    step();
    push(K_START, 64'h0, "start_one_cycle");
    sample();
    cmd(6'h2A);
    push(K_STATUS, st(1'b0, 1'b0, 1'b1), "status_badcmd");
    sample();
    pulse_event(8'h01);
    rd(3'd6, 8'h01, "flags_before_clrf");
    cmd(6'h02);
    push(K_STATUS, st(1'b0, 1'b0, 1'b0), "status_after_clrf");
    rd(3'd6, 8'h00, "flags_after_clrf");

    // Write and fast command together: write kept, command dropped.
    bus.reg_addr = 3'd2;
    bus.wr_data = 8'h5A;
    bus.wr_vld = 1'b1;
    bus.fastcmd = 6'h03;
    bus.fastcmd_vld = 1'b1;
    step();
    bus.wr_vld = 1'b0;
    bus.fastcmd_vld = 1'b0;
    exp_wcnt = exp_wcnt + 4'd1;
    push(K_START, 64'h0, "collide_no_start");
    push(K_STATUS, st(1'b0, 1'b0, 1'b0), "collide_status");
    rd(3'd2, 8'h5A, "collide_write_kept");

    // Asynchronous reset in the middle of a soft reset.
    cmd(6'h01);
    step();
    push(K_SRST, 64'h1, "srst_before_nrst");
    sample();
    step();
    nrst = 1'b0;
    exp_wcnt = '0;
    push(K_SRST, 64'h0, "srst_abort_nrst");
    push(K_STATUS, 64'h00, "status_abort_nrst");
    sample();
    nrst = 1'b1;
    step();
    push(K_SRST, 64'h0, "idle_after_nrst");
    push(K_STATUS, 64'h00, "status_idle_after_nrst");
    sample();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_regbank.md
# spi_regbank

Register bank directly downstream of the SPI register slave. Accepts byte-addressed write strobes and fast commands from the SPI slave, returns read data combinationally for the current address, and drives the status byte shifted out at the start of every SPI frame. Exposes configuration registers, a sticky event-flag register with mask and interrupt, and fast-command-driven soft reset and start pulses to the core logic.

## Interface
- ADDR_W, 3: register address width; register count NUM_REGS = 2**ADDR_W (minimum 4).
- REG_W, 8: register width; multiple of 8.
- SRST_CYC, 4: soft-reset pulse length in clk cycles (1..15).

- clk  in  1  system clock.
- nrst  in  1  reset nrst, asynchronous, active-low; clock clk.
- reg_addr  in  ADDR_W  current register address from the SPI slave.
- wr_data  in  REG_W  write data from the SPI slave.
- wr_vld  in  1  one-cycle write strobe.
- rd_data  out  REG_W  read data for reg_addr (combinational).
- status  out  8  status byte to the SPI slave.
- fastcmd  in  6  fast command code.
- fastcmd_vld  in  1  one-cycle fast command strobe.
- event_i  in  8  hardware event inputs.
- cfg_o  out  (NUM_REGS-2)*REG_W  config registers 0..NUM_REGS-3, register 0 in the LSBs.
- irq_o  out  1  interrupt, = |(FLAGS & MASK).
- start_o  out  1  one-cycle start pulse.
- soft_rst_o  out  1  soft-reset pulse to the core.

## Operation
- Address map: 0..NUM_REGS-3 are CFG (RW). NUM_REGS-2 is FLAGS (bits 7:0 sticky, W1C; upper bits read 0). NUM_REGS-1 is MASK (RW, bits 7:0; upper bits read 0, writes ignored).
- Write on wr_vld: the addressed register updates at the next clk edge. WR_CNT (4 bits) increments, wrapping 15 to 0.
- FLAGS: bit n sets when event_i[n] is high (see Configuration). A write of 1 clears the bit. Set and clear in the same cycle: set wins.
- Fast commands, decoded on fastcmd_vld:
  - 0x01 SRST: enter the soft-reset state.
  - 0x02 CLRF: clear FLAGS and BADCMD.
  - 0x03 START: start_o pulses for 1 cycle.
  - Any other code: BADCMD sticky set.
- FSM states: IDLE and SRST.
  - IDLE to SRST on SRST. Counter loads SRST_CYC.
  - In SRST: soft_rst_o=1; CFG, FLAGS, MASK and WR_CNT are held at 0; wr_vld is dropped and WR_CNT does not increment; fast commands are ignored; the counter decrements.
  - SRST to IDLE when the counter reaches 1.
- status = {irq_o, in_SRST, BADCMD, 1'b0, WR_CNT[3:0]}.
- Reset values: CFG, FLAGS, MASK, WR_CNT, BADCMD = 0; state IDLE; irq_o, start_o, soft_rst_o = 0; status = 0x00.

## Timing
- rd_data and status are combinational from registers and reg_addr. There is no latency; the SPI slave samples them later.
- A write is visible on rd_data, cfg_o and irq_o 1 cycle after the wr_vld edge.
- start_o is asserted in the cycle after the fastcmd_vld edge.
- soft_rst_o is high for exactly SRST_CYC cycles, starting 1 cycle after the strobe.
- Event to FLAGS set: 1 cycle without SPI_REGBANK_EVT_SYNC_EN, 3 cycles with it.
- wr_vld and fastcmd_vld are never asserted together (guaranteed by the upstream block). If they are, the write is processed and the fastcmd is dropped.
- Asynchronous nrst mid-operation aborts SRST immediately; all outputs go to their reset values.

## Configuration
- SPI_REGBANK_EVT_SYNC_EN defined: event_i passes through a 2-flop synchroniser, then a rising-edge detector. FLAGS bit sets only on a 0 to 1 transition.
- Undefined: event_i is treated as synchronous and level-sensitive. A high level sets the flag every cycle, so a W1C while the event is held high has no effect.

## Test plan
- Reset: check status=0x00, irq_o=0, cfg_o=0. Write 0xA5 to addr 0 and 0x3C to addr 5 -> rd_data reads 0xA5 and 0x3C; status[3:0]=2.
- 16 writes after reset -> WR_CNT wraps, status[3:0]=0. Write to MASK 0xFF -> rd_data=0xFF.
- MASK=0x04, pulse event_i[2] -> FLAGS=0x04, irq_o=1. Write 0x04 to FLAGS -> FLAGS=0, irq_o=0. Event and W1C in the same cycle -> flag stays set.
- fastcmd 0x01 with SRST_CYC=4 -> soft_rst_o high exactly 4 cycles, status[6]=1 during SRST. A write during SRST is dropped. Afterwards CFG=0 and status[3:0]=0.
- fastcmd 0x03 -> single-cycle start_o. fastcmd 0x2A -> status[5]=1. fastcmd 0x02 -> status[5]=0 and FLAGS=0.
- Assert nrst mid-SRST -> soft_rst_o=0 immediately, state IDLE. Repeat the event test with SPI_REGBANK_EVT_SYNC_EN: event held high sets the flag once, and W1C then clears it.
